// File: rtl/sc_cpu_pkg.sv
// rtl/sc_cpu_pkg.sv - shared types and constants for the single-cycle CPU fetch path
package sc_cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_MSB  = 5;
    localparam int FUNC_LSB  = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int INDEX_MSB = 25;

    localparam logic [31:0] SYSCALL_EXIT = 32'd10;

    // Word offset of a branch: sign-extend and scale by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/sc_next_pc.sv
// rtl/sc_next_pc.sv - combinational next-PC priority mux (JR > J/JAL > branch > sequential)
module sc_next_pc
    import sc_cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic [15:0] imm16,
    input  logic [31:0] rs_data,
    input  logic        jr,
    input  logic        jmp,
    input  logic        jal,
    input  logic        beq,
    input  logic        bne,
    input  logic        blez,
    input  logic        equal,
    input  logic        rs_lez,
    output logic [31:0] next_pc
);

    logic        taken;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign taken         = (beq & equal) | (bne & ~equal) | (blez & rs_lez);
    assign branch_target = pc_plus4 + branch_offset(imm16);
    assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = {rs_data[31:2], 2'b00};
        end else if (jmp || jal) begin
            next_pc = jump_target;
        end else if (taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/sc_fetch_sequencer.sv
// rtl/sc_fetch_sequencer.sv - FETCH/EXEC/HALT sequencer with PC register and retire counter
module sc_fetch_sequencer
    import sc_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [31:0]        Instr,
    input  logic               Beq,
    input  logic               Bne,
    input  logic               BLEZ,
    input  logic               JMP,
    input  logic               JR,
    input  logic               JAL,
    input  logic               SysCALL,
    input  logic               Equal,
    input  logic               RsLEZ,
    input  logic [31:0]        RsData,
    input  logic               SysHalt,
    input  logic               Stall,
    input  logic               Go,
    output logic [IMEM_AW-1:0] IMemAddr,
    output logic               IMemRd,
    output logic [5:0]         OP,
    output logic [5:0]         Func,
    output logic [4:0]         Rs,
    output logic [4:0]         Rt,
    output logic [4:0]         Rd,
    output logic [4:0]         Shamt,
    output logic [15:0]        Imm16,
    output logic [31:0]        PC,
    output logic [31:0]        PCPlus4,
    output logic               ExecEn,
    output logic               Halted,
    output logic [31:0]        InstrCount
);

    state_t      state, state_next;
    logic [31:0] pc_q;
    logic [31:0] count_q;
    logic [31:0] next_pc;
    logic        commit;
    logic        exit_call;

    assign OP    = Instr[OP_MSB:OP_LSB];
    assign Rs    = Instr[RS_MSB:RS_LSB];
    assign Rt    = Instr[RT_MSB:RT_LSB];
    assign Rd    = Instr[RD_MSB:RD_LSB];
    assign Shamt = Instr[SHAMT_MSB:SHAMT_LSB];
    assign Func  = Instr[FUNC_MSB:FUNC_LSB];
    assign Imm16 = Instr[IMM_MSB:IMM_LSB];

    assign PC         = pc_q;
    assign PCPlus4    = pc_q + 32'd4;
    assign IMemAddr   = pc_q[IMEM_AW+1:2];
    assign InstrCount = count_q;

    assign commit    = (state == EXEC) && !Stall;
    assign exit_call = SysCALL && SysHalt;

    sc_next_pc u_next_pc (
        .pc_plus4    (PCPlus4),
        .instr_index (Instr[INDEX_MSB:0]),
        .imm16       (Imm16),
        .rs_data     (RsData),
        .jr          (JR),
        .jmp         (JMP),
        .jal         (JAL),
        .beq         (Beq),
        .bne         (Bne),
        .blez        (BLEZ),
        .equal       (Equal),
        .rs_lez      (RsLEZ),
        .next_pc     (next_pc)
    );

    always_comb begin
        state_next = state;
        IMemRd     = 1'b0;
        ExecEn     = 1'b0;
        Halted     = 1'b0;
        case (state)
            FETCH: begin
                IMemRd     = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                ExecEn = !Stall;
                if (!Stall) begin
                    state_next = exit_call ? HALT : FETCH;
                end
            end
            HALT: begin
                Halted = 1'b1;
                if (Go) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else begin
            state <= state_next;
            if (commit) begin
                // An exit syscall still advances past itself so Go resumes at the next word.
                pc_q    <= exit_call ? PCPlus4 : next_pc;
                count_q <= count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sc_fetch_sequencer.sv
// tb/tb_sc_fetch_sequencer.sv - scoreboard bench for sc_fetch_sequencer
module tb_sc_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] Instr = 32'd0;
    logic        Beq, Bne, BLEZ, JMP, JR, JAL, SysCALL;
    logic        Equal, RsLEZ, SysHalt, Stall, Go;
    logic [31:0] RsData;
    logic [9:0]  IMemAddr;
    logic        IMemRd;
    logic [5:0]  OP, Func;
    logic [4:0]  Rs, Rt, Rd, Shamt;
    logic [15:0] Imm16;
    logic [31:0] PC, PCPlus4, InstrCount;
    logic        ExecEn, Halted;

    sc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
        .CLK(CLK), .RST_N(RST_N), .Instr(Instr),
        .Beq(Beq), .Bne(Bne), .BLEZ(BLEZ), .JMP(JMP), .JR(JR), .JAL(JAL), .SysCALL(SysCALL),
        .Equal(Equal), .RsLEZ(RsLEZ), .RsData(RsData), .SysHalt(SysHalt),
        .Stall(Stall), .Go(Go),
        .IMemAddr(IMemAddr), .IMemRd(IMemRd),
        .OP(OP), .Func(Func), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Imm16(Imm16),
        .PC(PC), .PCPlus4(PCPlus4), .ExecEn(ExecEn), .Halted(Halted), .InstrCount(InstrCount)
    );

    always #5 CLK = ~CLK;

    logic [31:0] rom [0:1023];
    always @(posedge CLK) if (IMemRd) Instr <= rom[IMemAddr];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] iw;
        logic [31:0] nxt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        pend;
    logic        pending = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] pc_model;
    logic [31:0] cnt_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        {JR, JMP, JAL, Beq, Bne, BLEZ, SysCALL} = 7'b0;
        Equal = 0; RsLEZ = 0; SysHalt = 0; Stall = 0; Go = 0; RsData = 32'd0;
    endtask

    // ctl = {jr, jmp, jal, beq, bne, blez, syscall}; called at posedge+2 while in FETCH
    task automatic step(input logic [31:0] iw, input logic [6:0] ctl, input logic eq,
                        input logic lez, input logic hlt, input logic [31:0] rs,
                        input int stalls, input logic [31:0] exp_next);
        exp_t e;
        chk("fetch_addr", 32'(IMemAddr), 32'(pc_model[11:2]));
        chk("fetch_rd", 32'(IMemRd), 32'd1);
        rom[pc_model[11:2]] = iw;
        e.pc = pc_model; e.pc4 = pc_model + 32'd4; e.iw = iw;
        e.nxt = exp_next; e.cnt = cnt_model + 32'd1;
        sb.push_back(e);
        {JR, JMP, JAL, Beq, Bne, BLEZ, SysCALL} = ctl;
        Equal = eq; RsLEZ = lez; SysHalt = hlt; RsData = rs; Stall = (stalls > 0);
        @(posedge CLK); #2;
        for (int i = 0; i < stalls; i++) begin
            chk("stall_execen", 32'(ExecEn), 32'd0);
            chk("stall_pc", PC, pc_model);
            chk("stall_cnt", InstrCount, cnt_model);
            @(posedge CLK); #2;
        end
        Stall = 0;
        @(posedge CLK); #2;
        clear_ctl();
        pc_model  = exp_next;
        cnt_model = cnt_model + 32'd1;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                chk("next_pc", PC, pend.nxt);
                chk("count_after", InstrCount, pend.cnt);
                pending = 1'b0;
            end
            if (ExecEn) begin
                chk("sb_size", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("commit_pc", PC, e.pc);
                    chk("pc_plus4", PCPlus4, e.pc4);
                    chk("op", 32'(OP), 32'(e.iw[31:26]));
                    chk("rs", 32'(Rs), 32'(e.iw[25:21]));
                    chk("rt", 32'(Rt), 32'(e.iw[20:16]));
                    chk("func", 32'(Func), 32'(e.iw[5:0]));
                    chk("imm16", 32'(Imm16), 32'(e.iw[15:0]));
                    chk("count_before", InstrCount, e.cnt - 32'd1);
                    pend    = e;
                    pending = 1'b1;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'd0;
        clear_ctl();
        RST_N = 1'b0;
        pc_model = 32'd0; cnt_model = 32'd0;
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_pc", PC, 32'd0);
        chk("rst_cnt", InstrCount, 32'd0);
        chk("rst_execen", 32'(ExecEn), 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);
        chk("rst_imemrd", 32'(IMemRd), 32'd1);
        RST_N = 1'b1;

        step(32'd0, 7'b0, 0, 0, 0, 0, 0, 32'h4);
        step(32'd0, 7'b0, 0, 0, 0, 0, 0, 32'h8);
        step(32'd0, 7'b0, 0, 0, 0, 0, 0, 32'hC);
        chk("count3", InstrCount, 32'd3);
        step({6'h02, 26'h10}, 7'b0100000, 0, 0, 0, 0, 0, 32'h40);
        step({6'h04, 5'd1, 5'd2, 16'hFFFC}, 7'b0001000, 1, 0, 0, 0, 0, 32'h34);
        step({6'h02, 26'h10}, 7'b0100000, 0, 0, 0, 0, 0, 32'h40);
        step({6'h04, 5'd1, 5'd2, 16'hFFFC}, 7'b0001000, 0, 0, 0, 0, 0, 32'h44);
        step({6'h05, 5'd1, 5'd2, 16'h002E}, 7'b0000100, 0, 0, 0, 0, 0, 32'h100);
        step({6'h00, 5'd3, 15'd0, 6'h08}, 7'b1100000, 0, 0, 0, 32'h203, 0, 32'h200);
        step({6'h00, 5'd3, 15'd0, 6'h08}, 7'b1000000, 0, 0, 0, 32'h100, 0, 32'h100);
        step({6'h03, 26'h10}, 7'b0010000, 0, 0, 0, 0, 0, 32'h40);
        step({6'h06, 5'd4, 5'd0, 16'h000F}, 7'b0000010, 0, 1, 0, 0, 0, 32'h80);
        step({6'h06, 5'd4, 5'd0, 16'h000F}, 7'b0000010, 0, 0, 0, 0, 0, 32'h84);
        step({6'h06, 5'd4, 5'd0, 16'hFFFE}, 7'b0000010, 0, 1, 0, 0, 0, 32'h80);
        step({26'd0, 6'h0C}, 7'b0000001, 0, 0, 0, 0, 0, 32'h84);
        step({6'h06, 5'd4, 5'd0, 16'hFFFE}, 7'b0000010, 0, 1, 0, 0, 0, 32'h80);

        step({26'd0, 6'h0C}, 7'b0000001, 0, 0, 1, 0, 0, 32'h84);
        chk("halt_halted", 32'(Halted), 32'd1);
        chk("halt_imemrd", 32'(IMemRd), 32'd0);
        chk("halt_execen", 32'(ExecEn), 32'd0);
        repeat (3) @(posedge CLK);
        #2;
        chk("halt_hold_halted", 32'(Halted), 32'd1);
        chk("halt_hold_cnt", InstrCount, cnt_model);
        chk("halt_hold_pc", PC, 32'h84);
        Go = 1'b1;
        @(posedge CLK); #2;
        Go = 1'b0;
        chk("go_halted", 32'(Halted), 32'd0);
        chk("go_imemrd", 32'(IMemRd), 32'd1);
        step(32'd0, 7'b0, 0, 0, 0, 0, 0, 32'h88);

        step(32'd0, 7'b0, 0, 0, 0, 0, 3, 32'h8C);
        step({6'h00, 5'd3, 15'd0, 6'h08}, 7'b1000000, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC);
        step(32'd0, 7'b0, 0, 0, 0, 0, 0, 32'h0);
        step(32'd0, 7'b0, 0, 0, 0, 0, 0, 32'h4);

        rom[1] = {6'h04, 5'd1, 5'd2, 16'h0010};
        Beq = 1'b1; Equal = 1'b1;
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_pc", PC, 32'd0);
        chk("midrst_cnt", InstrCount, 32'd0);
        chk("midrst_execen", 32'(ExecEn), 32'd0);
        chk("midrst_imemrd", 32'(IMemRd), 32'd1);
        @(posedge CLK); #2;
        chk("midrst_hold_pc", PC, 32'd0);
        clear_ctl();
        RST_N = 1'b1;
        pc_model = 32'd0; cnt_model = 32'd0;
        step(32'd0, 7'b0, 0, 0, 0, 0, 0, 32'h4);

        @(negedge CLK); #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
